t03_mem_request_arbiter: RTL and testbench



---
 rtl/t03_mem_pkg.sv | 32 +++
 rtl/t03_lane_align.sv | 48 ++++
 rtl/t03_mem_request_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_t03_mem_request_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_mem_pkg.sv
// Shared types and constants for the team_03 memory request unit.
package t03_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_ARM   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // addi x0, x0, 0 -- handed to the fetch channel when the bus never answers
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h3300_0000;

    // Half needs a[0]=0, word (and the unused size code 3) needs a[1:0]=0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return a[0];
            default: return (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/t03_lane_align.sv
// Byte-lane steering: bus byte enables, store-data replication and
// load-data extract/extend. Purely combinational.
module t03_lane_align
    import t03_mem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        fetch_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] bus_rdata_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Fetches are always full words; data accesses follow size and low address bits.
    always_comb begin
        shifted = bus_rdata_i >> {addr_lo_i, 3'b000};
        sel_o   = 4'hF;
        wdata_o = wdata_i;
        rdata_o = shifted;
        if (!fetch_i) begin
            case (size_i)
                SZ_BYTE: begin
                    sel_o   = 4'b0001 << addr_lo_i;
                    wdata_o = {4{wdata_i[7:0]}};
                    rdata_o = unsigned_i ? {24'h0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
                end
                SZ_HALF: begin
                    sel_o   = 4'b0011 << addr_lo_i;
                    wdata_o = {2{wdata_i[15:0]}};
                    rdata_o = unsigned_i ? {16'h0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
                end
                default: begin
                    sel_o   = 4'hF;
                    wdata_o = wdata_i;
                    rdata_o = shifted;
                end
            endcase
        end
    end

endmodule

// File: rtl/t03_mem_request_arbiter.sv
// Round-robin fetch / load-store arbiter onto the single Wishbone manager port.
// Optional bus-stall timeout: define T03_REQ_TIMEOUT_EN.
// Handshake: a channel raises its req with its fields and holds them until its
// ack pulse; fields are sampled only in IDLE. The bus side gets a one-cycle
// read_i/write_i strobe and signals completion by busy_o low in WAIT.
module t03_mem_request_arbiter
    import t03_mem_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter int                TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic              d_unsigned,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              read_i,
    output logic              write_i,
    output logic [ADDR_W-1:0] adr_i,
    output logic [31:0]       cpu_dat_i,
    output logic [3:0]        sel_i,
    input  logic [31:0]       cpu_dat_o,
    input  logic              busy_o,
    output logic [2:0]        dbg_state_o
);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1 = data was granted last
    logic              gnt_data_q, gnt_data_d;       // 1 = current owner is data
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_ph_q, err_ph_d;           // ERR: 0 = dead cycle, 1 = ack cycle
    logic              pick_data;

`ifdef T03_REQ_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYC != 0) ^ NOP_INSTR[0];
`endif

    logic        bus_phase;
    logic        ack_cyc;
    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    // Next-state: arbitration and request capture in IDLE, bus sequencing afterwards.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_data_d   = gnt_data_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_ph_d     = err_ph_q;
        pick_data    = 1'b0;
`ifdef T03_REQ_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    // On a tie the channel that did not win last time goes first.
                    pick_data    = d_req && (!i_req || !last_grant_q);
                    gnt_data_d   = pick_data;
                    last_grant_d = pick_data;
                    err_ph_d     = 1'b0;
`ifdef T03_REQ_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    if (pick_data) begin
                        we_d    = d_we;
                        size_d  = d_size;
                        uns_d   = d_unsigned;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        state_d = is_misaligned(d_size, d_addr[1:0]) ? ST_ERR : ST_ISSUE;
                    end else begin
                        we_d    = 1'b0;
                        size_d  = SZ_WORD;
                        uns_d   = 1'b0;
                        addr_d  = i_addr;
                        wdata_d = '0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: state_d = ST_ARM;
            ST_ARM:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (!busy_o) begin
                    if (!we_q) rdata_d = cpu_dat_o;
                    state_d = ST_RESP;
                end
`ifdef T03_REQ_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d  = ST_ERR;
                    err_ph_d = 1'b0;
                    if (!gnt_data_q) rdata_d = NOP_INSTR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR: begin
                if (!err_ph_q) err_ph_d = 1'b1;
                else           state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers: synchronous reset, frozen while en is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b0;
            gnt_data_q   <= 1'b0;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_ph_q     <= 1'b0;
`ifdef T03_REQ_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else if (en) begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_data_q   <= gnt_data_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_ph_q     <= err_ph_d;
`ifdef T03_REQ_TIMEOUT_EN
            cnt_q        <= cnt_d;
`endif
        end
    end

    t03_lane_align u_lane (
        .size_i      (size_q),
        .addr_lo_i   (addr_q[1:0]),
        .fetch_i     (!gnt_data_q),
        .unsigned_i  (uns_q),
        .wdata_i     (wdata_q),
        .bus_rdata_i (rdata_q),
        .sel_o       (lane_sel),
        .wdata_o     (lane_wdata),
        .rdata_o     (lane_rdata)
    );

    // Outputs decode from registered state only, so they hold whenever en is low.
    always_comb begin
        bus_phase   = (state_q == ST_ISSUE) || (state_q == ST_ARM) || (state_q == ST_WAIT);
        ack_cyc     = (state_q == ST_RESP) || ((state_q == ST_ERR) && err_ph_q);
        read_i      = (state_q == ST_ISSUE) && !we_q;
        write_i     = (state_q == ST_ISSUE) && we_q;
        adr_i       = bus_phase ? ({addr_q[ADDR_W-1:2], 2'b00} + BASE_ADDR) : '0;
        sel_i       = bus_phase ? lane_sel : 4'h0;
        cpu_dat_i   = (bus_phase && we_q) ? lane_wdata : 32'h0;
        i_ack       = ack_cyc && !gnt_data_q;
        d_ack       = ack_cyc && gnt_data_q;
        d_err       = (state_q == ST_ERR) && err_ph_q && gnt_data_q;
        i_rdata     = rdata_q;
        d_rdata     = lane_rdata;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_t03_mem_request_arbiter.sv
// Directed bench for t03_mem_request_arbiter with a scoreboard of expected acks.
module tb_t03_mem_request_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic        d_unsigned = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        read_i;
    logic        write_i;
    logic [31:0] adr_i;
    logic [31:0] cpu_dat_i;
    logic [3:0]  sel_i;
    logic [31:0] cpu_dat_o = '0;
    logic        busy_o;
    logic [2:0]  dbg_state_o;

    logic busy_resp = 1'b0;
    logic busy_force = 1'b0;
    int   busy_cfg = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Scoreboard entry: {check_data, expect_err, channel(1=data), data}
    logic [34:0] exp_q[$];
    logic [34:0] e;

    assign busy_o = busy_resp | busy_force;

    t03_mem_request_arbiter dut (
        .clk(clk), .rst(rst), .en(en),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .read_i(read_i), .write_i(write_i), .adr_i(adr_i), .cpu_dat_i(cpu_dat_i), .sel_i(sel_i),
        .cpu_dat_o(cpu_dat_o), .busy_o(busy_o), .dbg_state_o(dbg_state_o)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bus responder: after a strobe keep busy high through ARM and busy_cfg WAIT cycles.
    always begin
        @(negedge clk);
        if ((read_i || write_i) && busy_cfg > 0) begin
            busy_resp = 1'b1;
            repeat (busy_cfg + 2) @(negedge clk);
            busy_resp = 1'b0;
        end
    end

    // Scoreboard: every ack pops one expected entry.
    always @(negedge clk) begin
        if (!rst && (i_ack || d_ack)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'h0, i_ack, d_ack}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("ack_channel", {31'h0, d_ack}, {31'h0, e[32]});
                check("ack_exclusive", {31'h0, i_ack & d_ack}, 32'h0);
                if (d_ack) check("d_err", {31'h0, d_err}, {31'h0, e[33]});
                if (e[34]) check("rdata", d_ack ? d_rdata : i_rdata, e[31:0]);
            end
        end
    end

    task automatic wait_ack(input int c0, input int exp_lat);
        for (int k = 0; k < 600 && !(i_ack || d_ack); k++) @(negedge clk);
        if (!(i_ack || d_ack)) check("ack_timeout", 32'h0, 32'h1);
        else check("ack_latency", cyc - c0, exp_lat);
    endtask

    task automatic drop_reqs();
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // Driver: one full transaction on a single channel.
    task automatic txn(input logic ch, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] bus_word,
                       input int busy, input logic [31:0] exp_adr, input logic [3:0] exp_sel,
                       input logic [31:0] exp_wdat, input logic [31:0] exp_rdata, input int exp_lat);
        int c0;
        exp_q.push_back({!we, 1'b0, ch, exp_rdata});
        busy_cfg  = busy;
        cpu_dat_o = bus_word;
        if (ch) begin
            d_req = 1'b1; d_we = we; d_size = size; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        c0 = cyc;
        @(negedge clk);
        check("issue_read", {31'h0, read_i}, {31'h0, !we});
        check("issue_write", {31'h0, write_i}, {31'h0, we});
        check("issue_adr", adr_i, exp_adr);
        check("issue_sel", {28'h0, sel_i}, {28'h0, exp_sel});
        check("issue_wdat", cpu_dat_i, exp_wdat);
        @(negedge clk);
        check("strobe_one_cycle", {31'h0, read_i | write_i}, 32'h0);
        wait_ack(c0, exp_lat);
        drop_reqs();
        @(negedge clk);
        check("after_resp_adr", adr_i, 32'h0);
    endtask

    task automatic err_txn(input logic [1:0] size, input logic [31:0] addr);
        int c0;
        exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
        d_req = 1'b1; d_we = 1'b0; d_size = size; d_unsigned = 1'b0; d_addr = addr; d_wdata = '0;
        c0 = cyc;
        @(negedge clk);
        check("err_no_strobe", {31'h0, read_i | write_i}, 32'h0);
        @(negedge clk);
        check("err_no_strobe2", {31'h0, read_i | write_i}, 32'h0);
        check("err_ack_cycle", cyc - c0, 2);
        check("err_d_ack", {31'h0, d_ack}, 32'h1);
        drop_reqs();
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acks"}, {29'h0, i_ack, d_ack, d_err}, 32'h0);
        check({tag, "_strobes"}, {30'h0, read_i, write_i}, 32'h0);
        check({tag, "_adr"}, adr_i, 32'h0);
        check({tag, "_dat_sel"}, cpu_dat_i | {28'h0, sel_i}, 32'h0);
        check({tag, "_rdata"}, i_rdata | d_rdata, 32'h0);
        check({tag, "_state"}, {29'h0, dbg_state_o}, 32'h0);
    endtask

    initial begin
        int c0;
        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");

        // Word load at 0x100, three busy cycles
        txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 3,
            32'h3300_0100, 4'hF, 32'h0, 32'hCAFE_F00D, 7);
        // Signed / unsigned byte load at 0x103
        txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 0,
            32'h3300_0100, 4'b1000, 32'h0, 32'hFFFF_FF80, 4);
        txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 0,
            32'h3300_0100, 4'b1000, 32'h0, 32'h0000_0080, 4);
        // Half store of 0xBEEF at 0x22
        txn(1'b1, 1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF, 32'h0, 0,
            32'h3300_0020, 4'b1100, 32'hBEEF_BEEF, 32'h0, 4);
        // Signed half load from the upper half
        txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, 32'h8001_7FFF, 1,
            32'h3300_0000, 4'b1100, 32'h0, 32'hFFFF_8001, 5);
        // Byte store lane 1
        txn(1'b1, 1'b1, 2'd0, 1'b0, 32'h1, 32'h1234_56A5, 32'h0, 0,
            32'h3300_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0, 4);
        // Fetch from an unaligned PC reads the aligned word
        txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h106, 32'h0, 32'hDEAD_BEEF, 0,
            32'h3300_0104, 4'hF, 32'h0, 32'hDEAD_BEEF, 4);

        // Misaligned word and half
        err_txn(2'd2, 32'h101);
        err_txn(2'd1, 32'h3);

        // en low during ISSUE delays completion by exactly the frozen cycles
        exp_q.push_back({1'b1, 1'b0, 1'b1, 32'h55AA_55AA});
        busy_cfg = 0; cpu_dat_o = 32'h55AA_55AA;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_unsigned = 1'b0; d_addr = 32'h44;
        c0 = cyc;
        @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("en_hold_state", {29'h0, dbg_state_o}, 32'd1);
        check("en_hold_read", {31'h0, read_i}, 32'h1);
        en = 1'b1;
        wait_ack(c0, 7);
        drop_reqs();
        @(negedge clk);

        // Reset in WAIT aborts without an ack
        busy_cfg = 6;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h80;
        repeat (4) @(negedge clk);
        check("rst_in_wait_state", {29'h0, dbg_state_o}, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_abort");
        drop_reqs();
        rst = 1'b0;
        repeat (12) @(negedge clk);

        // Both channels held: D, I, D, I at 5-cycle spacing
        busy_cfg = 0; cpu_dat_o = 32'h1234_5678;
        for (int t = 0; t < 4; t++) exp_q.push_back({1'b1, 1'b0, t[0] ? 1'b0 : 1'b1, 32'h1234_5678});
        i_req = 1'b1; i_addr = 32'h203;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h40;
        c0 = cyc;
        for (int t = 0; t < 4; t++) begin
            wait_ack(c0, 4 + 5 * t);
            if (t == 3) drop_reqs();
            @(negedge clk);
        end
        repeat (3) @(negedge clk);

`ifdef T03_REQ_TIMEOUT_EN
        // Bus stuck busy: error ack after the timeout
        exp_q.push_back({1'b0, 1'b1, 1'b1, 32'h0});
        busy_force = 1'b1;
        d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h10;
        c0 = cyc;
        @(negedge clk);
        wait_ack(c0, 259);
        drop_reqs();
        busy_force = 1'b0;
        repeat (2) @(negedge clk);
`endif

        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
